// File: rtl/mem_port_sched.sv
// mem_port_sched: serialises fetch and data accesses onto one memory port.
// Data wins arbitration, but fetch is granted after MAX_DATA_RUN consecutive data grants.
module mem_port_sched #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);
    localparam int RW = $clog2(MAX_DATA_RUN + 1);
    localparam int WW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [RW-1:0]     run_cnt_q, run_cnt_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              d_any, data_win;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        run_cnt_d  = run_cnt_q;
        wait_cnt_d = wait_cnt_q;
        d_any      = d_read | d_write;
        data_win   = d_any && !(if_req && run_cnt_q == RW'(MAX_DATA_RUN));
        case (state_q)
            IDLE: if (d_any || if_req) begin
                state_d   = ISSUE;
                owner_d   = data_win;
                addr_d    = data_win ? d_addr : if_addr;
                wdata_d   = data_win ? d_wdata : '0;
                we_d      = data_win & d_write;
                // data only wins below the cap, so the increment cannot overflow
                run_cnt_d = (data_win && if_req) ? run_cnt_q + 1'b1 : '0;
                err_d     = err_q | (data_win & d_read & d_write);
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = WW'(MEM_LAT - 1);
            end
            WAIT: if (wait_cnt_q == '0) begin
                state_d    = DONE;
                d_rdata_d  = (!we_q && owner_q) ? mem_rdata : d_rdata_q;
                if_rdata_d = (!we_q && !owner_q) ? mem_rdata : if_rdata_q;
            end else begin
                wait_cnt_d = wait_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            run_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            run_cnt_q  <= run_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign mem_en    = state_q == ISSUE;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign d_ack     = state_q == DONE && owner_q;
    assign if_ack    = state_q == DONE && !owner_q;
    assign busy      = state_q != IDLE;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
endmodule
